// File: rtl/adder_core.sv
// Registered unsigned adder with a LATENCY-deep shift-chain pipeline.
// Ports: clock, reset (async active-low), in1/in2 operands, out = in1+in2 with carry in MSB.
module adder_core #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH:0]   out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] stage [LATENCY];

  // Zero-extend before adding so the carry lands in the top bit.
  assign sum = {1'b0, in1} + {1'b0, in2};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= sum;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out = stage[LATENCY-1];

endmodule

// File: tb/tb_adder_core.sv
// Directed bench for adder_core: one instance at LATENCY=1, one at LATENCY=3.
// Both share clock, reset and operands; expected sums are tracked per sampled edge.
module tb_adder_core;

  logic       clock;
  logic       reset;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [4:0] out1;
  logic [4:0] out3;

  int checks;
  int errors;

  logic [4:0] hist [$];

  adder_core #(.WIDTH(4), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .in1   (in1),
    .in2   (in2),
    .out   (out1)
  );

  adder_core #(.WIDTH(4), .LATENCY(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .in1   (in1),
    .in2   (in2),
    .out   (out3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a pair, let one rising edge sample it, settle 1 time unit.
  // While reset is low nothing is recorded, since nothing is sampled.
  task automatic tick(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    in1 = a;
    in2 = b;
    @(posedge clock);
    #1;
    s = {1'b0, a} + {1'b0, b};
    if (reset) hist.push_back(s);
  endtask

  function automatic logic [4:0] exp3();
    if (hist.size() >= 3) return hist[hist.size()-3];
    return 5'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      tick(4'hF, 4'hF);
      checks++;
      if (out1 !== 5'h00 || out3 !== 5'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d out1=%h out3=%h exp 00", i, out1, out3);
      end
      in1 = 4'h0;
      in2 = 4'h0;
      #2;
      in1 = 4'hF;
      in2 = 4'hF;
    end
    reset = 1'b1;
    tick(4'd6, 4'd4);
    tick(4'd2, 4'd3);
    tick(4'd1, 4'd1);
    #2;
    reset = 1'b0;
    hist.delete();
    #1;
    checks++;
    if (out1 !== 5'h00 || out3 !== 5'h00) begin
      errors++;
      $display("FAIL reset_async out1=%h out3=%h exp 00", out1, out3);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    tick(4'd3, 4'd5);
    checks++;
    if (out1 !== 5'd8) begin
      errors++;
      $display("FAIL basic_l1 out=%0d exp 8", out1);
    end
    checks++;
    if (out3 !== 5'd0) begin
      errors++;
      $display("FAIL basic_l3_early out=%0d exp 0", out3);
    end
    in1 = 4'd9;
    in2 = 4'd9;
    #3;
    checks++;
    if (out1 !== 5'd8) begin
      errors++;
      $display("FAIL hold_between_edges out=%0d exp 8", out1);
    end
    tick(4'd3, 4'd5);
    tick(4'd3, 4'd5);
    checks++;
    if (out3 !== 5'd8) begin
      errors++;
      $display("FAIL basic_l3 out=%0d exp 8", out3);
    end
  endtask

  task automatic test_carry();
    tick(4'hF, 4'h1);
    checks++;
    if (out1 !== 5'b10000) begin
      errors++;
      $display("FAIL carry_f_1 out=%b exp 10000", out1);
    end
    tick(4'hF, 4'hF);
    checks++;
    if (out1 !== 5'd30) begin
      errors++;
      $display("FAIL carry_max out=%0d exp 30", out1);
    end
    tick(4'h0, 4'h0);
    checks++;
    if (out3 !== 5'b10000) begin
      errors++;
      $display("FAIL carry_l3 out=%b exp 10000", out3);
    end
  endtask

  task automatic test_identity();
    tick(4'd0, 4'd0);
    checks++;
    if (out1 !== 5'd0) begin
      errors++;
      $display("FAIL zero out=%0d exp 0", out1);
    end
    tick(4'd0, 4'd9);
    checks++;
    if (out1 !== 5'd9) begin
      errors++;
      $display("FAIL ident_b out=%0d exp 9", out1);
    end
    tick(4'd7, 4'd0);
    checks++;
    if (out1 !== 5'd7) begin
      errors++;
      $display("FAIL ident_a out=%0d exp 7", out1);
    end
    checks++;
    if (out3 !== 5'd0) begin
      errors++;
      $display("FAIL ident_l3 out=%0d exp 0", out3);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] e;
    for (int i = 0; i < 20; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      tick(a, b);
      e = {1'b0, a} + {1'b0, b};
      checks++;
      if (out1 !== e) begin
        errors++;
        $display("FAIL b2b_l1 #%0d out=%0d exp %0d", i, out1, e);
      end
      e = exp3();
      checks++;
      if (out3 !== e) begin
        errors++;
        $display("FAIL b2b_l3 #%0d out=%0d exp %0d", i, out3, e);
      end
    end
  endtask

  task automatic test_midstream_reset();
    tick(4'd10, 4'd11);
    tick(4'd12, 4'd13);
    tick(4'd14, 4'd15);
    #2;
    reset = 1'b0;
    hist.delete();
    #1;
    checks++;
    if (out3 !== 5'd0 || out1 !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset out3=%0d out1=%0d exp 0", out3, out1);
    end
    tick(4'd1, 4'd2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(4'(i + 1), 4'd1);
      checks++;
      if (out3 !== exp3()) begin
        errors++;
        $display("FAIL post_reset #%0d out=%0d exp %0d", i, out3, exp3());
      end
      checks++;
      if (out1 !== 5'(i + 2)) begin
        errors++;
        $display("FAIL post_reset_l1 #%0d out=%0d exp %0d", i, out1, i + 2);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    in1    = 4'h0;
    in2    = 4'h0;
    #1;
    test_reset();
    test_basic();
    test_carry();
    test_identity();
    test_back_to_back();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
